// File: rtl/fabric_dispatcher_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fabric_dispatcher_if                                     |
// | Brief    : Host-side instruction stream, start/status and fabric   |
// |            row-side signals of the fabric dispatcher.              |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
interface fabric_dispatcher_if #(
    parameter int ROWS             = 1,
    parameter int INSTR_DATA_WIDTH = 27,
    parameter int INSTR_ADDR_WIDTH = 4,
    parameter int INSTR_HOPS_WIDTH = 4
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    // Host instruction stream
    logic                               s_valid;
    logic                               s_ready;
    logic [ROW_W-1:0]                   s_row;
    logic [INSTR_DATA_WIDTH-1:0]        s_data;
    logic [INSTR_ADDR_WIDTH-1:0]        s_addr;
    logic [INSTR_HOPS_WIDTH-1:0]        s_hops;

    // Execution control and status
    logic                               start;
    logic [ROWS-1:0]                    start_mask;
    logic                               busy;
    logic                               done;
    logic                               timeout;

    // Fabric row side
    logic [ROWS*INSTR_DATA_WIDTH-1:0]   instr_data_out;
    logic [ROWS*INSTR_ADDR_WIDTH-1:0]   instr_addr_out;
    logic [ROWS*INSTR_HOPS_WIDTH-1:0]   instr_hops_out;
    logic [ROWS-1:0]                    instr_en_out;
    logic [ROWS-1:0]                    call;
    logic [ROWS-1:0]                    ret;

    // Dispatcher side
    modport slave (
        input  s_valid, s_row, s_data, s_addr, s_hops, start, start_mask, ret,
        output s_ready, busy, done, timeout,
               instr_data_out, instr_addr_out, instr_hops_out, instr_en_out, call
    );

    // Host / fabric side
    modport master (
        output s_valid, s_row, s_data, s_addr, s_hops, start, start_mask, ret,
        input  s_ready, busy, done, timeout,
               instr_data_out, instr_addr_out, instr_hops_out, instr_en_out, call
    );
endinterface
`default_nettype wire

// File: rtl/fabric_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fabric_dispatcher                                        |
// | Brief    : Buffers host instruction words, injects them into the   |
// |            fabric row instruction chains, then calls the selected  |
// |            rows and waits for all of them to return.               |
// | Options  : FABRIC_DISPATCHER_TIMEOUT_EN - abort WAIT when the      |
// |            cycle counter reaches its maximum.                      |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module fabric_dispatcher #(
    parameter int ROWS             = 1,
    parameter int INSTR_DATA_WIDTH = 27,
    parameter int INSTR_ADDR_WIDTH = 4,
    parameter int INSTR_HOPS_WIDTH = 4,
    parameter int FIFO_DEPTH       = 8,
    parameter int RET_GUARD        = 2,
    parameter int TIMEOUT_WIDTH    = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fabric_dispatcher_if.slave bus
);
    localparam int c_ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_DW      = INSTR_DATA_WIDTH;
    localparam int c_AW      = INSTR_ADDR_WIDTH;
    localparam int c_HW      = INSTR_HOPS_WIDTH;
    localparam int c_ENTRY_W = c_ROW_W + c_DW + c_AW + c_HW;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CALL = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [c_PTR_W-1:0]       c_PTR_ONE   = {{(c_PTR_W-1){1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0]         c_CNT_ONE   = {{c_PTR_W{1'b0}}, 1'b1};
    localparam logic [c_PTR_W:0]         c_DEPTH     = (c_PTR_W+1)'(FIFO_DEPTH);
    localparam logic [TIMEOUT_WIDTH-1:0] c_TO_ONE    = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0] c_TO_MAX    = {TIMEOUT_WIDTH{1'b1}};
    localparam logic [TIMEOUT_WIDTH-1:0] c_RET_GUARD = TIMEOUT_WIDTH'(RET_GUARD);

    // FIFO storage and pointers
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_ENTRY_W-1:0] w_wr_entry;
    logic [c_ENTRY_W-1:0] w_rd_entry;
    logic [c_ROW_W-1:0]   w_rd_row;
    logic [c_DW-1:0]      w_rd_data;
    logic [c_AW-1:0]      w_rd_addr;
    logic [c_HW-1:0]      w_rd_hops;

    // Row-side instruction registers
    logic [ROWS-1:0]      r_instr_en;
    logic [ROWS*c_DW-1:0] r_instr_data;
    logic [ROWS*c_AW-1:0] r_instr_addr;
    logic [ROWS*c_HW-1:0] r_instr_hops;

    // Control
    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic                     r_pending;
    logic [ROWS-1:0]          r_mask;
    logic [TIMEOUT_WIDTH-1:0] r_cnt;
    logic                     w_start_acc;
    logic                     w_ret_ok;
    logic                     w_to_hit;

    assign w_full     = (r_count == c_DEPTH);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.s_valid && !w_full;
    assign w_pop      = (r_state == c_IDLE) && !w_empty;
    assign w_wr_entry = {bus.s_row, bus.s_data, bus.s_addr, bus.s_hops};
    assign w_rd_entry = r_mem[r_rd_ptr];
    assign {w_rd_row, w_rd_data, w_rd_addr, w_rd_hops} = w_rd_entry;

    // Storage array needs no reset: occupancy is tracked by r_count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_wr_entry;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            if (w_push && !w_pop)      r_count <= r_count + c_CNT_ONE;
            else if (!w_push && w_pop) r_count <= r_count - c_CNT_ONE;
        end
    end

    // One-cycle instruction injection; an out-of-range row matches no slot and is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_instr_en   <= '0;
            r_instr_data <= '0;
            r_instr_addr <= '0;
            r_instr_hops <= '0;
        end else begin
            for (int r = 0; r < ROWS; r++) begin
                if (w_pop && (w_rd_row == c_ROW_W'(r))) begin
                    r_instr_en[r]                <= 1'b1;
                    r_instr_data[r*c_DW +: c_DW] <= w_rd_data;
                    r_instr_addr[r*c_AW +: c_AW] <= w_rd_addr;
                    r_instr_hops[r*c_HW +: c_HW] <= w_rd_hops;
                end else begin
                    r_instr_en[r]                <= 1'b0;
                    r_instr_data[r*c_DW +: c_DW] <= '0;
                    r_instr_addr[r*c_AW +: c_AW] <= '0;
                    r_instr_hops[r*c_HW +: c_HW] <= '0;
                end
            end
        end
    end

    assign w_ret_ok = (r_cnt >= c_RET_GUARD) && ((bus.ret & r_mask) == r_mask);

`ifdef FABRIC_DISPATCHER_TIMEOUT_EN
    logic r_to_flag;
    assign w_to_hit = (r_state == c_WAIT) && !w_ret_ok && (r_cnt == c_TO_MAX);

    // Remembers that DONE was reached by abort rather than by ret
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_to_flag <= 1'b0;
        else     r_to_flag <= w_to_hit;
    end

    assign bus.timeout = (r_state == c_DONE) && r_to_flag;
`else
    assign w_to_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state; an empty FIFO means nothing pops now, so no en can share the CALL cycle
    always_comb begin
        w_state_nxt = r_state;
        w_start_acc = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_start_acc = !r_pending && bus.start && (bus.start_mask != '0);
                if ((r_pending || w_start_acc) && w_empty) w_state_nxt = c_CALL;
            end
            c_CALL:  w_state_nxt = c_WAIT;
            c_WAIT:  if (w_ret_ok || w_to_hit) w_state_nxt = c_DONE;
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Start bookkeeping: latch mask on acceptance, release at DONE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_mask    <= '0;
        end else if (w_start_acc) begin
            r_pending <= 1'b1;
            r_mask    <= bus.start_mask;
        end else if (r_state == c_DONE) begin
            r_pending <= 1'b0;
        end
    end

    // WAIT cycle counter: cleared in CALL, saturating in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == c_CALL) begin
            r_cnt <= '0;
        end else if ((r_state == c_WAIT) && (r_cnt != c_TO_MAX)) begin
            r_cnt <= r_cnt + c_TO_ONE;
        end
    end

    assign bus.s_ready        = !w_full;
    assign bus.busy           = r_pending || (r_state != c_IDLE);
    assign bus.done           = (r_state == c_DONE);
    assign bus.call           = (r_state == c_CALL) ? r_mask : '0;
    assign bus.instr_en_out   = r_instr_en;
    assign bus.instr_data_out = r_instr_data;
    assign bus.instr_addr_out = r_instr_addr;
    assign bus.instr_hops_out = r_instr_hops;

endmodule
`default_nettype wire

// File: tb/tb_fabric_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fabric_dispatcher                                     |
// | Brief    : Directed self-checking bench for fabric_dispatcher with  |
// |            a scoreboard of expected instruction injections.        |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_fabric_dispatcher;
    localparam int ROWS  = 3;
    localparam int ROW_W = 2;
    localparam int DW    = 27;
    localparam int AW    = 4;
    localparam int HW    = 4;
    localparam int DEPTH = 8;
    localparam int GUARD = 2;
    localparam int TOW   = 4;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [DW-1:0]    data;
        logic [AW-1:0]    addr;
        logic [HW-1:0]    hops;
    } entry_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     errors = 0;
    entry_t exp_q[$];

    fabric_dispatcher_if #(
        .ROWS(ROWS), .INSTR_DATA_WIDTH(DW), .INSTR_ADDR_WIDTH(AW), .INSTR_HOPS_WIDTH(HW)
    ) bus ();

    fabric_dispatcher #(
        .ROWS(ROWS), .INSTR_DATA_WIDTH(DW), .INSTR_ADDR_WIDTH(AW), .INSTR_HOPS_WIDTH(HW),
        .FIFO_DEPTH(DEPTH), .RET_GUARD(GUARD), .TIMEOUT_WIDTH(TOW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one push for the current cycle; record it if it will be accepted and injected
    task automatic push(input int row, input int data, input bit record);
        entry_t e;
        e.row  = ROW_W'(row);
        e.data = DW'(data);
        e.addr = AW'(data);
        e.hops = HW'(data >> 4);
        bus.s_valid = 1'b1;
        bus.s_row   = e.row;
        bus.s_data  = e.data;
        bus.s_addr  = e.addr;
        bus.s_hops  = e.hops;
        if (record && bus.s_ready && row < ROWS) exp_q.push_back(e);
    endtask

    task automatic idle();
        bus.s_valid = 1'b0;
    endtask

    // Scoreboard: every en pulse must match the oldest expected entry, only on its row
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.call != '0) check("call_vs_en", bus.instr_en_out, 0);
            for (int r = 0; r < ROWS; r++) begin
                if (bus.instr_en_out[r]) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_en", bus.instr_en_out, 0);
                    end else begin
                        entry_t e;
                        logic [ROWS*DW-1:0] ed;
                        logic [ROWS*AW-1:0] ea;
                        logic [ROWS*HW-1:0] eh;
                        e  = exp_q.pop_front();
                        ed = '0; ed[r*DW +: DW] = e.data;
                        ea = '0; ea[r*AW +: AW] = e.addr;
                        eh = '0; eh[r*HW +: HW] = e.hops;
                        check("en_row", r, e.row);
                        check("en_onehot", bus.instr_en_out, 1 << r);
                        check("en_data", bus.instr_data_out, ed);
                        check("en_addr", bus.instr_addr_out, ea);
                        check("en_hops", bus.instr_hops_out, eh);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0; bus.s_row = '0; bus.s_data = '0; bus.s_addr = '0; bus.s_hops = '0;
        bus.start = 1'b0; bus.start_mask = '0; bus.ret = '0;
        rst = 1'b1;
        step(); step();
        check("rst_s_ready", bus.s_ready, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_timeout", bus.timeout, 0);
        check("rst_call", bus.call, 0);
        check("rst_en", bus.instr_en_out, 0);
        check("rst_data", bus.instr_data_out, 0);
        rst = 1'b0;
        step();

        // Drain order: three pushes to row 0, en at t+2..t+4
        push(0, 'h1, 1); step();
        push(0, 'h2, 1); step();
        push(0, 'h3, 1); check("drain_en_t2", bus.instr_en_out, 3'b001); step();
        idle();          check("drain_en_t3", bus.instr_en_out, 3'b001); step();
        check("drain_en_t4", bus.instr_en_out, 3'b001); step();
        check("drain_en_t5", bus.instr_en_out, 3'b000);

        // Pending start with a non-empty FIFO
        push(1, 'h44, 1); step();
        push(0, 'h55, 1); bus.start = 1'b1; bus.start_mask = 3'b011; step();
        idle(); bus.start = 1'b0;
        check("pend_busy", bus.busy, 1);
        check("pend_call_a2", bus.call, 0);
        check("pend_en_a2", bus.instr_en_out, 3'b010); step();
        check("pend_en_a3", bus.instr_en_out, 3'b001);
        check("pend_call_a3", bus.call, 0); step();
        check("pend_call_a4", bus.call, 3'b011);
        check("pend_en_a4", bus.instr_en_out, 0); step();
        check("pend_call_a5", bus.call, 0);
        for (int i = 0; i < 5; i++) begin
            check("pend_wait_busy", bus.busy, 1);
            check("pend_wait_done", bus.done, 0);
            step();
        end
        bus.ret = 3'b011;
        check("pend_done_early", bus.done, 0); step();
        check("pend_done", bus.done, 1);
        check("pend_timeout", bus.timeout, 0);
        check("pend_busy_done", bus.busy, 1);
        bus.ret = '0; step();
        check("pend_done_gone", bus.done, 0);
        check("pend_busy_gone", bus.busy, 0);

        // Start on an empty FIFO; ret ignored during the guard window
        bus.start = 1'b1; bus.start_mask = 3'b100; step();
        bus.start = 1'b0;
        check("empty_busy", bus.busy, 1);
        check("empty_call", bus.call, 3'b100); step();
        bus.ret = 3'b100;
        check("guard_call_off", bus.call, 0);
        check("guard_done_c0", bus.done, 0); step();
        check("guard_done_c1", bus.done, 0); step();
        check("guard_done_c2", bus.done, 0); step();
        check("guard_done", bus.done, 1);
        bus.ret = '0; step();
        check("guard_busy_off", bus.busy, 0);

        // Zero mask start is ignored
        bus.start = 1'b1; bus.start_mask = '0; step();
        bus.start = 1'b0;
        check("zmask_busy", bus.busy, 0);
        check("zmask_call", bus.call, 0); step();
        check("zmask_busy2", bus.busy, 0);
        check("zmask_call2", bus.call, 0);

        // Invalid row is consumed without an en pulse
        push(3, 'h77, 1); step();
        idle(); step();
        check("badrow_en_t2", bus.instr_en_out, 0); step();
        check("badrow_en_t3", bus.instr_en_out, 0);
        check("badrow_ready", bus.s_ready, 1);

        // Backpressure: fill the FIFO while in WAIT
        bus.start = 1'b1; bus.start_mask = 3'b001; step();
        bus.start = 1'b0; step();
        for (int i = 0; i < DEPTH; i++) begin
            check("bp_ready", bus.s_ready, 1);
            push(i % ROWS, int'($urandom_range(0, 32'h7ffffff)), 1);
            step();
        end
        check("bp_full", bus.s_ready, 0);
        push(1, 'h99, 1); step();
        check("bp_stall", bus.s_ready, 0);
        check("bp_no_en", bus.instr_en_out, 0);
        bus.ret = 3'b001; step();
        idle(); bus.ret = '0;
        check("bp_done", bus.done, 1);
        check("bp_full_done", bus.s_ready, 0); step();
        check("bp_busy_off", bus.busy, 0); step();
        check("bp_ready_back", bus.s_ready, 1);
        for (int i = 0; i < DEPTH; i++) step();
        check("bp_drained", exp_q.size(), 0);
        check("bp_en_idle", bus.instr_en_out, 0);

        // Timeout behaviour with ret held low
        bus.start = 1'b1; bus.start_mask = 3'b010; step();
        bus.start = 1'b0; step();
        for (int i = 0; i < 16; i++) begin
            check("to_wait_done", bus.done, 0);
            check("to_wait_timeout", bus.timeout, 0);
            step();
        end
`ifdef FABRIC_DISPATCHER_TIMEOUT_EN
        check("to_done", bus.done, 1);
        check("to_timeout", bus.timeout, 1); step();
        check("to_busy_off", bus.busy, 0);
        check("to_timeout_off", bus.timeout, 0);
`else
        check("noto_done", bus.done, 0);
        check("noto_timeout", bus.timeout, 0);
        check("noto_busy", bus.busy, 1);
        bus.ret = 3'b010; step();
        check("noto_ret_done", bus.done, 1);
        check("noto_ret_timeout", bus.timeout, 0);
        bus.ret = '0; step();
        check("noto_busy_off", bus.busy, 0);
`endif

        // Reset in the middle of WAIT with entries buffered
        bus.start = 1'b1; bus.start_mask = 3'b001; step();
        bus.start = 1'b0; step();
        push(0, 'hAA, 0); step();
        push(1, 'hBB, 0); step();
        idle(); step();
        check("mid_busy_pre", bus.busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", bus.s_ready, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_call", bus.call, 0);
        check("mid_rst_en", bus.instr_en_out, 0);
        check("mid_rst_timeout", bus.timeout, 0);
        bus.ret = 3'b001; step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("post_rst_done", bus.done, 0);
            check("post_rst_en", bus.instr_en_out, 0);
            check("post_rst_busy", bus.busy, 0);
            step();
        end
        bus.ret = '0;
        check("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
